// File: rtl/ir_call_stack.sv
// Instruction register with BSR/RET decode and a hardware return-address stack.
// Every output is registered and updates together with IR_code on the load edge.
module ir_call_stack #(
  parameter int                IW       = 22,
  parameter int                AW       = 10,
  parameter int                OPW      = 12,
  parameter logic [OPW-1:0]    BSR_OP   = 12'b011100000000,
  parameter logic [IW-1:0]     RET_CODE = 22'b0000011000000000000000,
  parameter int                DEPTH    = 8,
  localparam int               SW       = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          HOLD,
  input  logic [IW-1:0] PR_code,
  input  logic [AW-1:0] pc,
  input  logic          clr_err,
  output logic [IW-1:0] IR_code,
  output logic          bsr_det,
  output logic          ret_det,
  output logic [AW-1:0] relative_jump,
  output logic [AW-1:0] target_pc,
  output logic [AW-1:0] ret_pc,
  output logic [SW-1:0] stack_depth,
  output logic          overflow,
  output logic          underflow
);

  localparam int AIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IW-1:0] ir_q, ir_d;
  logic          bsr_q, bsr_d, ret_q, ret_d;
  logic [AW-1:0] rel_q, rel_d, tgt_q, tgt_d, retpc_q, retpc_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic [AW-1:0] stack_q [DEPTH];

  logic          is_ret, is_bsr, full, empty, push_en, ovf_set, unf_set;
  logic [AW-1:0] pc_inc;
  logic [SW-1:0] ptr_dec;
  logic [AIW-1:0] wr_idx, rd_idx;

  assign is_ret  = (PR_code == RET_CODE);
  assign is_bsr  = (PR_code[IW-1:IW-OPW] == BSR_OP) && !is_ret;
  assign full    = (ptr_q == SW'(DEPTH));
  assign empty   = (ptr_q == '0);
  assign pc_inc  = pc + AW'(1);
  assign ptr_dec = ptr_q - SW'(1);
  assign wr_idx  = ptr_q[AIW-1:0];
  assign rd_idx  = ptr_dec[AIW-1:0];

  always_comb begin
    ir_d     = ir_q;
    bsr_d    = bsr_q;
    ret_d    = ret_q;
    rel_d    = rel_q;
    tgt_d    = tgt_q;
    retpc_d  = retpc_q;
    ptr_d    = ptr_q;
    push_en  = 1'b0;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    if (!HOLD) begin
      ir_d  = PR_code;
      bsr_d = is_bsr;
      ret_d = is_ret;
      if (is_bsr) begin
        rel_d = PR_code[AW-1:0];
        // Offset is AW bits wide, so sign extension is a no-op modulo 2^AW.
        tgt_d = pc_inc + PR_code[AW-1:0];
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          push_en = 1'b1;
          ptr_d   = ptr_q + SW'(1);
        end
      end else if (is_ret) begin
        if (empty) begin
          retpc_d = '0;
          unf_set = 1'b1;
        end else begin
          retpc_d = stack_q[rd_idx];
          ptr_d   = ptr_dec;
        end
      end
    end
    // A new error on the same edge as clr_err wins over the clear.
    ovf_d = (ovf_q & ~clr_err) | ovf_set;
    unf_d = (unf_q & ~clr_err) | unf_set;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ir_q    <= '0;
      bsr_q   <= 1'b0;
      ret_q   <= 1'b0;
      rel_q   <= '0;
      tgt_q   <= '0;
      retpc_q <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      bsr_q   <= bsr_d;
      ret_q   <= ret_d;
      rel_q   <= rel_d;
      tgt_q   <= tgt_d;
      retpc_q <= retpc_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entries above the pointer are don't-care, so the storage needs no reset.
  always_ff @(posedge CLK) begin
    if (push_en) begin
      stack_q[wr_idx] <= pc_inc;
    end
  end

  assign IR_code       = ir_q;
  assign bsr_det       = bsr_q;
  assign ret_det       = ret_q;
  assign relative_jump = rel_q;
  assign target_pc     = tgt_q;
  assign ret_pc        = retpc_q;
  assign stack_depth   = ptr_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;

endmodule

// File: tb/tb_ir_call_stack.sv
// Directed bench for ir_call_stack: queue-based reference model checked every cycle,
// plus hand-computed expectations at the interesting points.
module tb_ir_call_stack;

  localparam int             IW       = 22;
  localparam int             AW       = 10;
  localparam int             OPW      = 12;
  localparam int             DEPTH    = 4;
  localparam int             SW       = $clog2(DEPTH + 1);
  localparam logic [OPW-1:0] BSR_OP   = 12'b011100000000;
  localparam logic [IW-1:0]  RET_CODE = 22'b0000011000000000000000;
  localparam logic [IW-1:0]  NOP_CODE = 22'h012345;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b1;
  logic          HOLD = 1'b0;
  logic [IW-1:0] PR_code = '0;
  logic [AW-1:0] pc = '0;
  logic          clr_err = 1'b0;
  logic [IW-1:0] IR_code;
  logic          bsr_det, ret_det, overflow, underflow;
  logic [AW-1:0] relative_jump, target_pc, ret_pc;
  logic [SW-1:0] stack_depth;

  ir_call_stack #(
    .IW(IW), .AW(AW), .OPW(OPW), .BSR_OP(BSR_OP), .RET_CODE(RET_CODE), .DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .HOLD(HOLD), .PR_code(PR_code), .pc(pc),
    .clr_err(clr_err), .IR_code(IR_code), .bsr_det(bsr_det), .ret_det(ret_det),
    .relative_jump(relative_jump), .target_pc(target_pc), .ret_pc(ret_pc),
    .stack_depth(stack_depth), .overflow(overflow), .underflow(underflow)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [IW-1:0] exp_ir;
  logic          exp_bsr, exp_ret, exp_ovf, exp_unf;
  logic [AW-1:0] exp_rel, exp_tgt, exp_retpc;
  logic [AW-1:0] ras[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    exp_ir = '0; exp_bsr = 0; exp_ret = 0; exp_rel = '0; exp_tgt = '0;
    exp_retpc = '0; exp_ovf = 0; exp_unf = 0;
    ras.delete();
  endtask

  // Applies the instruction-set rules to the inputs present at this edge.
  task automatic model_update();
    logic ov, un;
    int   off;
    ov = 0; un = 0;
    if (!HOLD) begin
      exp_ir  = PR_code;
      exp_ret = (PR_code == RET_CODE);
      exp_bsr = (PR_code[IW-1:IW-OPW] == BSR_OP) && !exp_ret;
      if (exp_bsr) begin
        off     = PR_code[AW-1] ? int'(PR_code[AW-1:0]) - (1 << AW) : int'(PR_code[AW-1:0]);
        exp_rel = PR_code[AW-1:0];
        exp_tgt = AW'((int'(pc) + 1 + off) & ((1 << AW) - 1));
        if (ras.size() < DEPTH) ras.push_back(AW'(int'(pc) + 1));
        else ov = 1;
      end else if (exp_ret) begin
        if (ras.size() == 0) begin
          exp_retpc = '0;
          un = 1;
        end else begin
          exp_retpc = ras.pop_back();
        end
      end
    end
    exp_ovf = (clr_err ? 1'b0 : exp_ovf) | ov;
    exp_unf = (clr_err ? 1'b0 : exp_unf) | un;
  endtask

  task automatic compare_all();
    chk("IR_code", 32'(IR_code), 32'(exp_ir));
    chk("bsr_det", 32'(bsr_det), 32'(exp_bsr));
    chk("ret_det", 32'(ret_det), 32'(exp_ret));
    chk("relative_jump", 32'(relative_jump), 32'(exp_rel));
    chk("target_pc", 32'(target_pc), 32'(exp_tgt));
    chk("ret_pc", 32'(ret_pc), 32'(exp_retpc));
    chk("stack_depth", 32'(stack_depth), 32'(ras.size()));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("underflow", 32'(underflow), 32'(exp_unf));
    $display("cycle t=%0t ir=0x%06h bsr=%0b ret=%0b tgt=0x%03h rpc=0x%03h depth=%0d ovf=%0b unf=%0b",
             $time, IR_code, bsr_det, ret_det, target_pc, ret_pc, stack_depth, overflow, underflow);
  endtask

  task automatic step();
    @(posedge CLK);
    if (RESET_N) model_update();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic do_bsr(input logic [AW-1:0] p, input logic [AW-1:0] off);
    PR_code = {BSR_OP, off};
    pc      = p;
    step();
  endtask

  task automatic do_ret();
    PR_code = RET_CODE;
    step();
  endtask

  task automatic do_nop();
    PR_code = NOP_CODE;
    step();
  endtask

  initial begin
    model_reset();
    #1 RESET_N = 1'b0;
    #1;
    chk("reset IR_code", 32'(IR_code), 0);
    chk("reset stack_depth", 32'(stack_depth), 0);
    chk("reset flags", {29'd0, bsr_det, ret_det, overflow | underflow}, 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    do_bsr(10'h010, 10'h005);
    chk("t1 bsr_det", 32'(bsr_det), 1);
    chk("t1 target_pc", 32'(target_pc), 32'h016);
    chk("t1 relative_jump", 32'(relative_jump), 32'h005);
    chk("t1 depth", 32'(stack_depth), 1);
    do_ret();
    chk("t1 ret_pc", 32'(ret_pc), 32'h011);

    do_bsr(10'h000, 10'h3FE);
    chk("t2 target_pc wrap", 32'(target_pc), 32'h3FF);
    do_ret();
    chk("t2 ret_det", 32'(ret_det), 1);
    chk("t2 ret_pc", 32'(ret_pc), 32'h001);
    chk("t2 depth", 32'(stack_depth), 0);

    for (int i = 0; i < 5; i++) begin
      do_bsr(AW'(10'h100 + i), 10'h000);
      if (i == 3) begin
        chk("t3 full depth", 32'(stack_depth), 4);
        chk("t3 no overflow at full", 32'(overflow), 0);
      end
    end
    chk("t3 overflow", 32'(overflow), 1);
    chk("t3 bsr_det on overflow", 32'(bsr_det), 1);
    chk("t3 depth held", 32'(stack_depth), 4);
    for (int i = 0; i < 4; i++) begin
      do_ret();
      chk("t3 ret order", 32'(ret_pc), 32'(10'h104 - i));
    end
    chk("t3 underflow at last pop", 32'(underflow), 0);
    clr_err = 1'b1;
    do_nop();
    clr_err = 1'b0;
    chk("t3 overflow cleared", 32'(overflow), 0);

    do_ret();
    chk("t4 empty ret_pc", 32'(ret_pc), 0);
    chk("t4 underflow", 32'(underflow), 1);
    clr_err = 1'b1;
    do_nop();
    chk("t4 underflow cleared", 32'(underflow), 0);
    do_ret();
    clr_err = 1'b0;
    chk("t4 set beats clear", 32'(underflow), 1);

    do_bsr(10'h200, 10'h010);
    HOLD    = 1'b1;
    PR_code = RET_CODE;
    for (int i = 0; i < 3; i++) begin
      clr_err = (i == 1);
      step();
      chk("t5 hold IR_code", 32'(IR_code), 32'({BSR_OP, 10'h010}));
      chk("t5 hold depth", 32'(stack_depth), 1);
      chk("t5 hold ret_det", 32'(ret_det), 0);
    end
    clr_err = 1'b0;
    chk("t5 clear under hold", 32'(underflow), 0);
    HOLD = 1'b0;
    step();
    chk("t5 ret after hold", 32'(ret_pc), 32'h201);
    chk("t5 depth after hold", 32'(stack_depth), 0);
    do_nop();
    chk("t5 ret applied once", 32'(ret_det), 0);

    do_bsr(10'h3FF, 10'h001);
    chk("t6 pc wrap target", 32'(target_pc), 32'h001);
    do_ret();
    chk("t6 b2b ret_pc", 32'(ret_pc), 32'h000);
    do_bsr(10'h050, 10'h200);
    do_bsr(10'h060, 10'h1FF);
    do_ret();
    chk("t6 lifo top", 32'(ret_pc), 32'h061);
    do_bsr(10'h070, 10'h3F0);
    do_ret();
    do_ret();
    chk("t6 lifo bottom", 32'(ret_pc), 32'h051);

    do_bsr(10'h300, 10'h001);
    do_bsr(10'h301, 10'h002);
    #2 RESET_N = 1'b0;
    model_reset();
    #1;
    chk("t7 async IR_code", 32'(IR_code), 0);
    chk("t7 async depth", 32'(stack_depth), 0);
    chk("t7 async target_pc", 32'(target_pc), 0);
    chk("t7 async bsr_det", 32'(bsr_det), 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    do_ret();
    chk("t7 underflow after reset", 32'(underflow), 1);
    chk("t7 ret_pc after reset", 32'(ret_pc), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
